stopwatch_cu_ext: RTL
=====================

Name: stopwatch_cu_ext

Overview:
Parametrised next-generation stopwatch control unit. Merges debounced push-button events and UART command bytes into one stop/run/lap/clear state machine, and drives the stopwatch datapath (run enable, lap display hold, clear pulse). Adds lap hold, a stopwatch/watch mode toggle, configurable command bytes, a configurable clear-pulse width and unknown-command flagging. Sits between the button debouncers / UART RX FIFO and the stopwatch datapath and display mux.

Parameters:
CMD_RUN, 8'h52 ("R"), byte that toggles run/stop
CMD_CLEAR, 8'h43 ("C"), byte that requests clear
CMD_STOP, 8'h53 ("S"), byte that forces STOP from any state
CMD_LAP, 8'h4C ("L"), byte that toggles lap hold
CMD_MODE, 8'h4D ("M"), byte that toggles stopwatch/watch mode
CASE_INSENSITIVE, 1, when 1 the lowercase form (byte | 8'h20) of each command is also accepted
CLEAR_CYCLES, 1, clear pulse width in clocks (range 1..255)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-low
btn_R  in  1  debounced run/stop button, level
btn_L  in  1  debounced clear/lap button, level
btn_U  in  1  debounced mode button, level
rx_valid  in  1  one-cycle strobe: rx_data holds a new byte
rx_data  in  8  received UART byte
run_stop  out  1  datapath count enable
clear  out  1  datapath clear, CLEAR_CYCLES wide
lap_hold  out  1  freeze displayed time while counting continues
mode  out  1  0 = stopwatch displayed, 1 = watch displayed
cmd_err  out  1  one-cycle pulse on an unrecognised rx byte
state  out  2  current FSM state (debug/LED)

Behaviour:
- Reset (rst=0 at a clk edge): state=STOP, all outputs 0, clear counter 0, button history registers 0.
- Button events are rising edges of btn_R, btn_L and btn_U, detected against the previous-cycle sample. A held button produces exactly one event. The history register updates during reset to 0.
- A UART event requires rx_valid=1 and an rx_data match. Bytes are ignored when rx_valid=0.
- run_ev = (btn_R edge & mode==0) | uart CMD_RUN
- l_ev = btn_L edge & mode==0
- clr_ev = (l_ev in STOP) | uart CMD_CLEAR
- lap_ev = (l_ev in RUN/LAP) | uart CMD_LAP
- mode_ev = btn_U edge | uart CMD_MODE
- stop_ev = uart CMD_STOP
- In watch mode (mode=1), btn_R and btn_L are ignored by this block. UART commands still act.
- cmd_err: pulses 1 cycle after rx_valid with a byte matching no command.
- States are STOP=0, RUN=1, LAP=2, CLEAR=3. All outputs are registered, and a state change is visible one clk after the triggering event cycle.
- Priority, highest first: rst, stop_ev, then per-state rules.
  - stop_ev in any state: go to STOP, lap_hold=0, clear=0. This aborts CLEAR.
  - STOP: run_ev goes to RUN; else clr_ev goes to CLEAR. lap_ev is ignored. If run_ev and clr_ev occur together, RUN wins.
  - RUN: run_ev goes to STOP; else lap_ev goes to LAP. clr_ev is ignored.
  - LAP: run_ev goes to STOP and releases lap_hold; else lap_ev goes back to RUN. clr_ev is ignored.
  - CLEAR: clear=1 for exactly CLEAR_CYCLES cycles, then STOP. All events except stop_ev are ignored.
- Outputs by state:
  - run_stop = 1 in RUN and LAP.
  - lap_hold = 1 in LAP only.
  - clear = 1 in CLEAR only.
- mode toggles on mode_ev in any state, including CLEAR. This is independent of the FSM: the stopwatch keeps running while the watch is displayed. stop_ev does not change mode.
- A button event and a UART event of the same kind in the same cycle count as a single event (OR), not two toggles.
- Clear counter: 8 bits, loaded with CLEAR_CYCLES-1 on entry to CLEAR, decremented each cycle; exit when it reaches 0.
- Reset asserted in any state, including mid-CLEAR, returns everything to reset values on that edge.

Decomposition:
- Shared package stopwatch_pkg:
  - state encoding constants STOP/RUN/LAP/CLEAR
  - default command byte constants
  - CASE_MASK = 8'h20
- Sub-module btn_edge_det: parametrised WIDTH, sync active-low reset, registered history, outputs a combinational rising-edge vector. Instantiated once with WIDTH=3.
- Command decode and FSM stay in the top module.

Test Plan:
- Reset then btn_R held high for 10 cycles -> run_stop=1 from the 2nd edge onward and stays 1. Only one toggle occurs, and state=1.
- RUN, then rx_valid with 8'h6C ("l") and CASE_INSENSITIVE=1 -> lap_hold=1, run_stop=1, state=2. A second "L" -> lap_hold=0, state=1.
- STOP with CLEAR_CYCLES=4, then btn_L edge -> clear=1 for exactly 4 cycles, then state=0, clear=0.
- In CLEAR (cycle 2 of 4), rx "S" -> clear=0 next cycle and state=0. Separately, rst=0 mid-CLEAR -> all outputs 0.
- Same cycle: btn_R edge and rx "R" in STOP -> state=RUN (single toggle). btn_R edge and rx "C" in STOP -> RUN wins, clear stays 0.
- rx "M" -> mode=1. Then btn_R edge -> no change. Then rx "R" -> run_stop=1. Then rx 8'h51 ("Q") -> cmd_err pulses for exactly 1 cycle.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control unit: state encoding, default
// command bytes and the command-byte matcher.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    StStop  = 2'd0,
    StRun   = 2'd1,
    StLap   = 2'd2,
    StClear = 2'd3
  } sw_state_e;

  localparam logic [7:0] DEF_CMD_RUN   = 8'h52;
  localparam logic [7:0] DEF_CMD_CLEAR = 8'h43;
  localparam logic [7:0] DEF_CMD_STOP  = 8'h53;
  localparam logic [7:0] DEF_CMD_LAP   = 8'h4C;
  localparam logic [7:0] DEF_CMD_MODE  = 8'h4D;
  localparam logic [7:0] CASE_MASK     = 8'h20;

  // Lowercase alternative is the command with bit 5 forced high.
  function automatic logic cmd_match(input logic [7:0] data, input logic [7:0] cmd,
                                     input logic ci);
    return (data == cmd) || (ci && (data == (cmd | CASE_MASK)));
  endfunction

endpackage

// File: rtl/btn_edge_det.sv
// Rising-edge detector for a vector of debounced button levels; history is
// cleared by a synchronous active-low reset.
module btn_edge_det #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_btn,
  output logic [WIDTH-1:0] o_rise
);

  logic [WIDTH-1:0] r_hist;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_hist <= '0;
    else          r_hist <= i_btn;
  end

  assign o_rise = i_btn & ~r_hist;

endmodule

// File: rtl/stopwatch_cu_ext.sv
// Stopwatch control unit: merges button edges and UART command bytes into a
// stop/run/lap/clear FSM plus an independent stopwatch/watch mode toggle.
module stopwatch_cu_ext
  import stopwatch_pkg::*;
#(
  parameter logic [7:0]  CMD_RUN          = DEF_CMD_RUN,
  parameter logic [7:0]  CMD_CLEAR        = DEF_CMD_CLEAR,
  parameter logic [7:0]  CMD_STOP         = DEF_CMD_STOP,
  parameter logic [7:0]  CMD_LAP          = DEF_CMD_LAP,
  parameter logic [7:0]  CMD_MODE         = DEF_CMD_MODE,
  parameter bit          CASE_INSENSITIVE = 1'b1,
  parameter int unsigned CLEAR_CYCLES     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_R,
  input  logic       btn_L,
  input  logic       btn_U,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       run_stop,
  output logic       clear,
  output logic       lap_hold,
  output logic       mode,
  output logic       cmd_err,
  output logic [1:0] state
);

  localparam logic [7:0] CLR_LOAD = 8'(CLEAR_CYCLES - 1);

  logic [2:0] w_rise;
  logic       w_u_run, w_u_clr, w_u_stop, w_u_lap, w_u_mode, w_u_any;
  logic       w_l_ev, w_run_ev, w_clr_ev, w_lap_ev, w_mode_ev, w_stop_ev;
  sw_state_e  r_state, w_state_d;
  logic [7:0] r_cnt, w_cnt_d;
  logic       r_run_stop, r_clear, r_lap_hold, r_mode, r_cmd_err;

  btn_edge_det #(
    .WIDTH(3)
  ) u_edge (
    .i_clk  (clk),
    .i_rst_n(rst),
    .i_btn  ({btn_U, btn_L, btn_R}),
    .o_rise (w_rise)
  );

  always_comb begin
    w_u_run  = rx_valid && cmd_match(rx_data, CMD_RUN, CASE_INSENSITIVE);
    w_u_clr  = rx_valid && cmd_match(rx_data, CMD_CLEAR, CASE_INSENSITIVE);
    w_u_stop = rx_valid && cmd_match(rx_data, CMD_STOP, CASE_INSENSITIVE);
    w_u_lap  = rx_valid && cmd_match(rx_data, CMD_LAP, CASE_INSENSITIVE);
    w_u_mode = rx_valid && cmd_match(rx_data, CMD_MODE, CASE_INSENSITIVE);
    w_u_any  = w_u_run || w_u_clr || w_u_stop || w_u_lap || w_u_mode;

    // Run/clear buttons belong to the watch display while mode is set.
    w_l_ev    = w_rise[1] && !r_mode;
    w_run_ev  = (w_rise[0] && !r_mode) || w_u_run;
    w_clr_ev  = (w_l_ev && (r_state == StStop)) || w_u_clr;
    w_lap_ev  = (w_l_ev && ((r_state == StRun) || (r_state == StLap))) || w_u_lap;
    w_mode_ev = w_rise[2] || w_u_mode;
    w_stop_ev = w_u_stop;
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    if (w_stop_ev) begin
      w_state_d = StStop;
      w_cnt_d   = 8'd0;
    end else begin
      unique case (r_state)
        StStop: begin
          if (w_run_ev) begin
            w_state_d = StRun;
          end else if (w_clr_ev) begin
            w_state_d = StClear;
            w_cnt_d   = CLR_LOAD;
          end
        end
        StRun: begin
          if (w_run_ev)      w_state_d = StStop;
          else if (w_lap_ev) w_state_d = StLap;
        end
        StLap: begin
          if (w_run_ev)      w_state_d = StStop;
          else if (w_lap_ev) w_state_d = StRun;
        end
        StClear: begin
          if (r_cnt == 8'd0) w_state_d = StStop;
          else               w_cnt_d   = r_cnt - 8'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= StStop;
      r_cnt      <= 8'd0;
      r_run_stop <= 1'b0;
      r_clear    <= 1'b0;
      r_lap_hold <= 1'b0;
      r_mode     <= 1'b0;
      r_cmd_err  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_run_stop <= (w_state_d == StRun) || (w_state_d == StLap);
      r_clear    <= (w_state_d == StClear);
      r_lap_hold <= (w_state_d == StLap);
      r_mode     <= r_mode ^ w_mode_ev;
      r_cmd_err  <= rx_valid && !w_u_any;
    end
  end

  assign run_stop = r_run_stop;
  assign clear    = r_clear;
  assign lap_hold = r_lap_hold;
  assign mode     = r_mode;
  assign cmd_err  = r_cmd_err;
  assign state    = r_state;

endmodule
